// File: rtl/mips_pkg.sv
// mips_pkg: shared load-type encodings, FIFO states and datapath defaults for the MEM/WB stage.
package mips_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        LD_WORD  = 2'b00,
        LD_BYTE  = 2'b01,
        LD_HALF  = 2'b10,
        LD_BYTEU = 2'b11
    } load_type_e;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } wb_state_e;
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the loaded byte/halfword out of the memory word and extends it.
// Sub-word extraction only exists with WB_LOAD_EXT_EN defined; otherwise the word passes through.
module load_extend
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [1:0]        i_load_type,
    input  logic [1:0]        i_byte_off,
    output logic [DATA_W-1:0] o_data
);
`ifdef WB_LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    // Little-endian: byte offset n selects bits [8n+7:8n]
    assign w_byte = i_mem_data[{i_byte_off, 3'b000} +: 8];
    assign w_half = i_byte_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    assign o_data = (i_load_type == LD_BYTE)  ? {{(DATA_W-8){w_byte[7]}}, w_byte} :
                    (i_load_type == LD_HALF)  ? {{(DATA_W-16){w_half[15]}}, w_half} :
                    (i_load_type == LD_BYTEU) ? {{(DATA_W-8){1'b0}}, w_byte} :
                                                i_mem_data;
`else
    logic w_unused;
    assign w_unused = ^{i_load_type, i_byte_off};
    assign o_data   = i_mem_data;
`endif
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: 2-entry write-back FIFO between MEM and the register-file write port.
// Load extension is enabled by defining WB_LOAD_EXT_EN.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic              inRegWrite,
    input  logic              inMemToReg,
    input  logic [DATA_W-1:0] inAluResult,
    input  logic [DATA_W-1:0] inMemData,
    input  logic [ADDR_W-1:0] inDestAddr,
    input  logic [1:0]        inLoadType,
    input  logic [1:0]        inByteOff,
    input  logic              rdReq,
    output logic              regWrite,
    output logic [DATA_W-1:0] write_back,
    output logic [ADDR_W-1:0] address1,
    output logic [15:0]       stallCount
);
    wb_state_e         r_state;
    logic [DATA_W-1:0] r_data0, r_data1;
    logic [ADDR_W-1:0] r_addr0, r_addr1;
    logic [DATA_W-1:0] w_ext, w_wdata;
    logic              w_push, w_pop;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .i_mem_data (inMemData),
        .i_load_type(inLoadType),
        .i_byte_off (inByteOff),
        .o_data     (w_ext)
    );

    assign w_wdata    = inMemToReg ? w_ext : inAluResult;
    assign inReady    = (r_state != TWO);
    // Non-writing entries are handshaken but never occupy a slot
    assign w_push     = inValid && inReady && inRegWrite && (inDestAddr != '0);
    assign regWrite   = (r_state != EMPTY) && !rdReq;
    assign w_pop      = regWrite;
    assign write_back = (r_state == EMPTY) ? '0 : r_data0;
    assign address1   = (r_state == EMPTY) ? '0 : r_addr0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_data0    <= '0;
            r_data1    <= '0;
            r_addr0    <= '0;
            r_addr1    <= '0;
            stallCount <= '0;
        end else begin
            if (r_state != EMPTY && rdReq && stallCount != 16'hFFFF)
                stallCount <= stallCount + 16'd1;
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_data0 <= w_wdata;
                        r_addr0 <= inDestAddr;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_data0 <= w_wdata;
                        r_addr0 <= inDestAddr;
                    end else if (w_push) begin
                        r_data1 <= w_wdata;
                        r_addr1 <= inDestAddr;
                        r_state <= TWO;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    // Head is only replaced once it has been written out
                    if (w_pop) begin
                        r_data0 <= r_data1;
                        r_addr0 <= r_addr1;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table-driven single-push vectors plus hand-written stall and reset sequences.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        inValid, inReady, inRegWrite, inMemToReg;
    logic [31:0] inAluResult, inMemData;
    logic [4:0]  inDestAddr;
    logic [1:0]  inLoadType, inByteOff;
    logic        rdReq, regWrite;
    logic [31:0] write_back;
    logic [4:0]  address1;
    logic [15:0] stallCount;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dst;
        logic [1:0]  lt;
        logic [1:0]  off;
        logic        we;
        logic [31:0] wb;
        logic [4:0]  addr;
    } vec_t;

    vec_t vecs[$];

    mem_wb_stage dut (
        .clk        (clk),
        .reset      (reset),
        .inValid    (inValid),
        .inReady    (inReady),
        .inRegWrite (inRegWrite),
        .inMemToReg (inMemToReg),
        .inAluResult(inAluResult),
        .inMemData  (inMemData),
        .inDestAddr (inDestAddr),
        .inLoadType (inLoadType),
        .inByteOff  (inByteOff),
        .rdReq      (rdReq),
        .regWrite   (regWrite),
        .write_back (write_back),
        .address1   (address1),
        .stallCount (stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] dst, input logic [1:0] lt,
                       input logic [1:0] off, input logic we, input logic [31:0] wb);
        vec_t v;
        v.name = nm; v.rw = rw; v.m2r = m2r; v.alu = alu; v.mem = mem; v.dst = dst;
        v.lt = lt; v.off = off; v.we = we; v.wb = we ? wb : 32'h0; v.addr = we ? dst : 5'd0;
        vecs.push_back(v);
    endtask

    task automatic push(input logic [4:0] dst, input logic [31:0] alu);
        inValid = 1'b1; inRegWrite = 1'b1; inMemToReg = 1'b0;
        inAluResult = alu; inDestAddr = dst;
    endtask

    initial begin
        add("alu_r9",    1, 0, 32'h0000_1234, 32'hFFFF_FFFF, 5'd9,  2'b00, 2'b00, 1, 32'h0000_1234);
        add("alu_mux",   1, 0, 32'hA5A5_A5A5, 32'h1111_2222, 5'd17, 2'b01, 2'b10, 1, 32'hA5A5_A5A5);
        add("word_load", 1, 1, 32'h0,         32'hDEAD_BEEF, 5'd7,  2'b00, 2'b11, 1, 32'hDEAD_BEEF);
`ifdef WB_LOAD_EXT_EN
        add("lb_off3",   1, 1, 32'h0, 32'h80FF_7F01, 5'd3,  2'b01, 2'd3, 1, 32'hFFFF_FF80);
        add("lh_off2",   1, 1, 32'h0, 32'h80FF_7F01, 5'd4,  2'b10, 2'd2, 1, 32'hFFFF_80FF);
        add("lbu_off1",  1, 1, 32'h0, 32'h80FF_7F01, 5'd31, 2'b11, 2'd1, 1, 32'h0000_007F);
        add("lh_off0",   1, 1, 32'h0, 32'h0000_8001, 5'd12, 2'b10, 2'd0, 1, 32'hFFFF_8001);
        add("lb_off0",   1, 1, 32'h0, 32'h80FF_7F01, 5'd13, 2'b01, 2'd0, 1, 32'h0000_0001);
`else
        add("lb_off3",   1, 1, 32'h0, 32'h80FF_7F01, 5'd3,  2'b01, 2'd3, 1, 32'h80FF_7F01);
        add("lh_off2",   1, 1, 32'h0, 32'h80FF_7F01, 5'd4,  2'b10, 2'd2, 1, 32'h80FF_7F01);
        add("lbu_off1",  1, 1, 32'h0, 32'h80FF_7F01, 5'd31, 2'b11, 2'd1, 1, 32'h80FF_7F01);
        add("lh_off0",   1, 1, 32'h0, 32'h0000_8001, 5'd12, 2'b10, 2'd0, 1, 32'h0000_8001);
        add("lb_off0",   1, 1, 32'h0, 32'h80FF_7F01, 5'd13, 2'b01, 2'd0, 1, 32'h80FF_7F01);
`endif
        add("dest_zero", 1, 0, 32'h0000_5555, 32'h0,         5'd0,  2'b00, 2'b00, 0, 32'h0);
        add("no_regwr",  0, 0, 32'h0000_6666, 32'h0,         5'd5,  2'b00, 2'b00, 0, 32'h0);

        reset = 1'b1; inValid = 0; inRegWrite = 0; inMemToReg = 0; inAluResult = '0;
        inMemData = '0; inDestAddr = '0; inLoadType = '0; inByteOff = '0; rdReq = 0;
        #2;
        chk("rst_regWrite", {31'b0, regWrite}, 32'd0);
        chk("rst_write_back", write_back, 32'd0);
        chk("rst_address1", {27'b0, address1}, 32'd0);
        chk("rst_stallCount", {16'b0, stallCount}, 32'd0);
        chk("rst_inReady", {31'b0, inReady}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            inValid = 1'b1; inRegWrite = vecs[i].rw; inMemToReg = vecs[i].m2r;
            inAluResult = vecs[i].alu; inMemData = vecs[i].mem; inDestAddr = vecs[i].dst;
            inLoadType = vecs[i].lt; inByteOff = vecs[i].off;
            chk({vecs[i].name, "_ready"}, {31'b0, inReady}, 32'd1);
            step();
            inValid = 1'b0;
            chk({vecs[i].name, "_we"}, {31'b0, regWrite}, {31'b0, vecs[i].we});
            chk({vecs[i].name, "_data"}, write_back, vecs[i].wb);
            chk({vecs[i].name, "_addr"}, {27'b0, address1}, {27'b0, vecs[i].addr});
            step();
            chk({vecs[i].name, "_drained"}, {31'b0, regWrite}, 32'd0);
        end

        // Three back-to-back pushes while decode owns the port
        rdReq = 1'b1;
        push(5'd1, 32'h0000_00A1);
        step();
        chk("stall_ready1", {31'b0, inReady}, 32'd1);
        push(5'd2, 32'h0000_00B2);
        step();
        chk("stall_full", {31'b0, inReady}, 32'd0);
        chk("stall_no_we", {31'b0, regWrite}, 32'd0);
        push(5'd3, 32'h0000_00C3);
        step(); step(); step();
        chk("stall_count4", {16'b0, stallCount}, 32'd4);
        chk("stall_held", {31'b0, inReady}, 32'd0);
        rdReq = 1'b0;
        #1;
        chk("order1_we", {31'b0, regWrite}, 32'd1);
        chk("order1_addr", {27'b0, address1}, 32'd1);
        chk("order1_data", write_back, 32'h0000_00A1);
        step();
        chk("order2_addr", {27'b0, address1}, 32'd2);
        chk("order2_data", write_back, 32'h0000_00B2);
        chk("order2_ready", {31'b0, inReady}, 32'd1);
        step();
        inValid = 1'b0;
        chk("order3_we", {31'b0, regWrite}, 32'd1);
        chk("order3_addr", {27'b0, address1}, 32'd3);
        chk("order3_data", write_back, 32'h0000_00C3);
        step();
        chk("order_drained", {31'b0, regWrite}, 32'd0);
        chk("stall_kept", {16'b0, stallCount}, 32'd4);

        // Reset mid-cycle with both slots full and decode holding the port
        rdReq = 1'b1;
        push(5'd10, 32'h0000_0A0A);
        step();
        push(5'd11, 32'h0000_0B0B);
        step();
        inValid = 1'b0;
        chk("pre_rst_full", {31'b0, inReady}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_write_back", write_back, 32'd0);
        chk("arst_address1", {27'b0, address1}, 32'd0);
        chk("arst_stallCount", {16'b0, stallCount}, 32'd0);
        chk("arst_inReady", {31'b0, inReady}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        rdReq = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_we", {31'b0, regWrite}, 32'd0);
        end
        push(5'd20, 32'h0000_2020);
        step();
        inValid = 1'b0;
        chk("post_rst_we", {31'b0, regWrite}, 32'd1);
        chk("post_rst_data", write_back, 32'h0000_2020);
        chk("post_rst_addr", {27'b0, address1}, 32'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port inValid  input  1  MEM stage presents an entry.
REQ-006 SHALL have port inReady  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port inRegWrite  input  1  entry writes a register.
REQ-008 SHALL have port inMemToReg  input  1  1 = select load data, 0 = select ALU result.
REQ-009 SHALL have port inAluResult  input  DATA_W  ALU result.
REQ-010 SHALL have port inMemData  input  DATA_W  raw memory word.
REQ-011 SHALL have port inDestAddr  input  ADDR_W  destination register.
REQ-012 SHALL have port inLoadType  input  2  00 word, 01 byte signed, 10 half signed, 11 byte unsigned.
REQ-013 SHALL have port inByteOff  input  2  byte offset of the load address.
REQ-014 SHALL have port rdReq  input  1  decode claims the register-file port this cycle.
REQ-015 SHALL have port regWrite  output  1  write strobe to the register file.
REQ-016 SHALL have port write_back  output  DATA_W  write data to the register file.
REQ-017 SHALL have port address1  output  ADDR_W  write address to the register file.
REQ-018 SHALL have port stallCount  output  16  saturating count of cycles a pending write was held by rdReq.

Function
REQ-019 SHALL hold a 2-entry FIFO; state EMPTY/ONE/TWO from occupancy; inReady = (state != TWO).
REQ-020 SHALL push on inValid && inReady at the rising edge, except entries with inRegWrite=0 or inDestAddr=0, which are accepted and discarded.
REQ-021 SHALL compute the stored data at push: inMemToReg ? extended inMemData : inAluResult.
REQ-022 SHALL drive regWrite = (state != EMPTY) && !rdReq, with write_back/address1 taken from the head entry; zero when EMPTY.
REQ-023 SHALL pop the head at the edge ending any cycle with regWrite=1; minimum latency is one cycle from push edge to regWrite high.
REQ-024 SHALL, on simultaneous push and pop in ONE, remain in ONE with the new entry as head; in TWO no push occurs.
REQ-025 SHALL preserve order; the entry at address1 is never overwritten while regWrite is low.
REQ-026 SHALL increment stallCount in each cycle with state != EMPTY && rdReq, saturating at 16'hFFFF.

Reset
REQ-027 SHALL on reset immediately force state EMPTY, regWrite=0, write_back=0, address1=0, stallCount=0, inReady=1.
REQ-028 SHALL discard pending entries on reset asserted mid-operation; no write issues after reset release until a new push.

Configuration
REQ-029 SHALL, with WB_LOAD_EXT_EN defined, extract byte/halfword per inByteOff (little-endian; halfword uses inByteOff[1]) and sign/zero-extend per inLoadType.
REQ-030 SHALL, without WB_LOAD_EXT_EN, ignore inLoadType/inByteOff and pass inMemData as the full word.

Structure
REQ-031 SHALL take the load-type encodings and DATA_W/ADDR_W defaults from shared package mips_pkg.
REQ-032 SHALL place the extraction/extension logic in combinational sub-module load_extend.

Verification
REQ-033 Push ALU 32'h0000_1234 to reg 9, rdReq=0 -> next cycle regWrite=1, address1=9, write_back=32'h0000_1234, then EMPTY.
REQ-034 Three back-to-back pushes with rdReq=1 for 4 cycles -> inReady=0 after two, third held upstream, stallCount=4, writes emerge in order on release.
REQ-035 Push to reg 0 and push with inRegWrite=0 -> no regWrite pulse, state stays EMPTY.
REQ-036 WB_LOAD_EXT_EN defined, inMemData=32'h80FF_7F01, byte signed offset 3 -> 32'hFFFF_FF80; half signed offset 2 -> 32'hFFFF_80FF; byte unsigned offset 1 -> 32'h0000_007F.
REQ-037 Reset asserted with state TWO and rdReq=1 -> outputs zero asynchronously, no write after release, stallCount=0.
